// File: rtl/mips_cpu_pc_seq.sv
// Program-counter sequencer with architectural branch delay slots, stall hold,
// exception redirect and halt. Optional JR alignment check: MIPS_PC_ALIGN_CHECK_EN.
module mips_cpu_pc_seq #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic [1:0]  i_pc_ctrl,
  input  logic        i_branch_taken,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_reg_readdata,
  input  logic        i_exc_req,
  output logic [31:0] o_pc_out,
  output logic [31:0] o_pc_link,
  output logic        o_in_delay_slot,
  output logic        o_active,
  output logic        o_fault
);

  // state      | meaning
  // ST_RUN     | sequential fetch, redirect requests accepted
  // ST_PENDING | pc is the delay slot, r_tgt is taken on the next unstalled edge
  // ST_HALTED  | pc frozen at HALT_ADDR until reset
  typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_HALTED} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic        r_fault;
  logic        r_active;
  logic        r_in_ds;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_raw_tgt;
  logic [31:0] w_tgt;
  logic        w_redirect;
  logic        w_fault_set;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_tgt   = w_pc_plus4 + {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_j_tgt    = {w_pc_plus4[31:28], i_instr[25:0], 2'b00};

  always_comb begin
    w_redirect = 1'b0;
    w_raw_tgt  = w_pc_plus4;
    case (i_pc_ctrl)
      2'd1: begin
        w_redirect = i_branch_taken;
        w_raw_tgt  = w_br_tgt;
      end
      2'd2: begin
        w_redirect = 1'b1;
        w_raw_tgt  = w_j_tgt;
      end
      2'd3: begin
        w_redirect = 1'b1;
        w_raw_tgt  = i_reg_readdata;
      end
      default: ;
    endcase
  end

`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign  = (w_raw_tgt[1:0] != 2'b00);
  assign w_tgt       = w_misalign ? EXC_VECTOR : w_raw_tgt;
  assign w_fault_set = w_redirect & w_misalign;
`else
  assign w_tgt       = w_raw_tgt & ~32'h3;
  assign w_fault_set = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_VECTOR;
      r_tgt    <= 32'h0;
      r_fault  <= 1'b0;
      r_active <= 1'b1;
      r_in_ds  <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        ST_HALTED: ;
        default: begin
          if (i_exc_req) begin
            r_pc    <= EXC_VECTOR;
            r_tgt   <= 32'h0;
            r_state <= ST_RUN;
            r_in_ds <= 1'b0;
          end else if (!i_stall) begin
            if (r_state == ST_PENDING) begin
              r_pc    <= r_tgt;
              r_in_ds <= 1'b0;
              if (r_tgt == HALT_ADDR) begin
                r_state  <= ST_HALTED;
                r_active <= 1'b0;
              end else begin
                r_state <= ST_RUN;
              end
            end else begin
              r_pc <= w_pc_plus4;
              // Landing on the halt address wins over a redirect from this slot.
              if (w_pc_plus4 == HALT_ADDR) begin
                r_state  <= ST_HALTED;
                r_active <= 1'b0;
              end else if (w_redirect) begin
                r_tgt   <= w_tgt;
                r_state <= ST_PENDING;
                r_in_ds <= 1'b1;
                r_fault <= w_fault_set;
              end
            end
          end
        end
      endcase
    end
  end

  assign o_pc_out        = r_pc;
  assign o_pc_link       = r_pc + 32'd8;
  assign o_in_delay_slot = r_in_ds;
  assign o_active        = r_active;
  assign o_fault         = r_fault;

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Bench for mips_cpu_pc_seq: directed vector table plus randomized run
// against a rule-level reference model.
module tb_mips_cpu_pc_seq;

  localparam logic [31:0] EXC  = 32'hBFC00380;
  localparam logic [31:0] HALT = 32'h00000000;
`ifdef MIPS_PC_ALIGN_CHECK_EN
  localparam logic [31:0] AL_PC = 32'hBFC00380;
  localparam logic        AL_F  = 1'b1;
`else
  localparam logic [31:0] AL_PC = 32'h80000000;
  localparam logic        AL_F  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, bt, exc;
  logic [1:0]  ctrl;
  logic [31:0] instr, rd;
  logic [31:0] pc_out, pc_link;
  logic        in_ds, active, fault;

  always #5 clk = ~clk;

  mips_cpu_pc_seq dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_pc_ctrl(ctrl),
    .i_branch_taken(bt), .i_instr(instr), .i_reg_readdata(rd), .i_exc_req(exc),
    .o_pc_out(pc_out), .o_pc_link(pc_link), .o_in_delay_slot(in_ds),
    .o_active(active), .o_fault(fault)
  );

  typedef struct {
    logic        rst, stall;
    logic [1:0]  ctrl;
    logic        bt;
    logic [31:0] instr, rd;
    logic        exc;
    logic [31:0] epc;
    logic        eds, eact, ef;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic s, input logic [1:0] c, input logic b,
                      input logic [31:0] ins, input logic [31:0] r_d, input logic e,
                      input logic [31:0] p, input logic ds, input logic a, input logic f);
    vec_t v;
    v = '{r, s, c, b, ins, r_d, e, p, ds, a, f};
    vecs.push_back(v);
  endtask

  // Reference model: architectural PC rules.
  logic [31:0] m_pc, m_tgt;
  logic        m_slot, m_halted, m_fault;

  task automatic model_step();
    logic [31:0] t, seq;
    logic        req, f;
    f = 1'b0;
    if (!rst) begin
      m_pc = 32'hBFC00000; m_tgt = 0; m_slot = 0; m_halted = 0;
    end else if (m_halted) begin
    end else if (exc) begin
      m_pc = EXC; m_slot = 0;
    end else if (!stall) begin
      if (m_slot) begin
        m_pc = m_tgt; m_slot = 0;
        if (m_pc == HALT) m_halted = 1;
      end else begin
        seq = m_pc + 4;
        req = (ctrl == 2'd2) || (ctrl == 2'd3) || (ctrl == 2'd1 && bt);
        case (ctrl)
          2'd1: t = seq + {{14{instr[15]}}, instr[15:0], 2'b00};
          2'd2: t = {seq[31:28], instr[25:0], 2'b00};
          default: t = rd;
        endcase
        m_pc = seq;
        if (m_pc == HALT) m_halted = 1;
        else if (req) begin
          m_slot = 1;
`ifdef MIPS_PC_ALIGN_CHECK_EN
          if (t % 4 != 0) begin t = EXC; f = 1'b1; end
`else
          t = t - (t % 4);
`endif
          m_tgt = t;
        end
      end
    end
    m_fault = f;
  endtask

  initial begin
    rst = 0; stall = 0; ctrl = 0; bt = 0; instr = 0; rd = 0; exc = 0;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      addv(0, $urandom, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
           32'hBFC00000, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00004, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00008, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC0000C, 0, 1, 0);
    addv(1, 0, 1, 0, 32'h00000004, 0, 0, 32'hBFC00010, 0, 1, 0);
    addv(1, 0, 1, 1, 32'h00000004, 0, 0, 32'hBFC00014, 1, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00024, 0, 1, 0);
    addv(1, 0, 1, 1, 32'h0000FFFA, 0, 0, 32'hBFC00028, 1, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00010, 0, 1, 0);
    addv(1, 0, 1, 1, 32'h0000FFFF, 0, 0, 32'hBFC00014, 1, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00010, 0, 1, 0);
    // jump, stall twice in the delay slot, branch in delay slot ignored
    addv(1, 0, 2, 0, 32'h0BF00040, 0, 0, 32'hBFC00014, 1, 1, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 32'hBFC00014, 1, 1, 0);
    addv(1, 1, 3, 0, 0, 32'h11111110, 0, 32'hBFC00014, 1, 1, 0);
    addv(1, 0, 1, 1, 32'h00000040, 0, 0, 32'hBFC00100, 0, 1, 0);
    addv(1, 1, 2, 0, 32'h0000FFFF, 0, 0, 32'hBFC00100, 0, 1, 0);
    // exception in a fresh delay slot, even while stalled
    addv(1, 0, 3, 0, 0, 32'h12345678, 0, 32'hBFC00104, 1, 1, 0);
    addv(1, 1, 0, 0, 0, 0, 1, EXC, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00384, 0, 1, 0);
    // halt via JR 0 at BFC00020
    addv(1, 0, 1, 1, 32'h0000FF26, 0, 0, 32'hBFC00388, 1, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 32'hBFC00020, 0, 1, 0);
    addv(1, 0, 3, 0, 0, 32'h00000000, 0, 32'hBFC00024, 1, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, HALT, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addv(1, $urandom, 2'($urandom), $urandom, $urandom, $urandom, 1, HALT, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 32'hBFC00000, 0, 1, 0);
    // misaligned JR
    addv(1, 0, 3, 0, 0, 32'h80000002, 0, 32'hBFC00004, 1, 1, AL_F);
    addv(1, 0, 0, 0, 0, 0, 0, AL_PC, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 0, AL_PC + 32'd4, 0, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall; ctrl = vecs[i].ctrl; bt = vecs[i].bt;
      instr = vecs[i].instr; rd = vecs[i].rd; exc = vecs[i].exc;
      @(posedge clk); #1;
      check($sformatf("row%0d pc", i), pc_out, vecs[i].epc);
      check($sformatf("row%0d link", i), pc_link, vecs[i].epc + 32'd8);
      check($sformatf("row%0d ds", i), 32'(in_ds), 32'(vecs[i].eds));
      check($sformatf("row%0d active", i), 32'(active), 32'(vecs[i].eact));
      check($sformatf("row%0d fault", i), 32'(fault), 32'(vecs[i].ef));
    end

    // randomized run against the model
    rst = 0; model_step(); @(posedge clk); #1;
    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(0, 40) != 0);
      stall = ($urandom_range(0, 3) == 0);
      exc   = ($urandom_range(0, 15) == 0);
      ctrl  = 2'($urandom);
      bt    = 1'($urandom);
      instr = $urandom;
      case ($urandom_range(0, 7))
        0: rd = 32'h0;
        1, 2: rd = $urandom;
        default: rd = $urandom & ~32'h3;
      endcase
      model_step();
      @(posedge clk); #1;
      check($sformatf("rnd%0d pc", n), pc_out, m_pc);
      check($sformatf("rnd%0d link", n), pc_link, m_pc + 32'd8);
      check($sformatf("rnd%0d ds", n), 32'(in_ds), 32'(m_slot));
      check($sformatf("rnd%0d active", n), 32'(active), 32'(!m_halted));
      check($sformatf("rnd%0d fault", n), 32'(fault), 32'(m_fault));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_pc_seq.md
# mips_cpu_pc_seq

Parametrised program-counter sequencer for the MIPS CPU, successor to the single-cycle PC unit. It generates the fetch address each cycle and implements architectural branch delay slots: the redirect takes effect after the delay-slot instruction, not immediately. It also supports pipeline stall hold, exception redirect, and a halt state entered on a jump to a configurable halt address. It sits between the decode/register-file logic (control and targets) and instruction fetch (`pc_out`).

## Interface

**Parameters**
- `RESET_VECTOR`, default 32'hBFC00000: `pc_out` value after reset.
- `EXC_VECTOR`, default 32'hBFC00380: redirect target on `exc_req` or an alignment fault.
- `HALT_ADDR`, default 32'h00000000: reaching this PC drops `active` and freezes the block.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `stall` in 1: 1 holds all state, except that `exc_req` is still honoured.
- `pc_ctrl` in 2: 0 = sequential, 1 = conditional branch, 2 = J/JAL, 3 = JR/JALR.
- `branch_taken` in 1: qualifies `pc_ctrl`=1; ignored otherwise.
- `instr` in 32: instruction currently at `pc_out`.
- `reg_readdata` in 32: rs value, used for `pc_ctrl`=3.
- `exc_req` in 1: exception redirect; highest priority.
- `pc_out` out 32: fetch address, registered.
- `pc_link` out 32: `pc_out`+8 (combinational), the JAL/JALR link value.
- `in_delay_slot` out 1: 1 while `pc_out` is a delay-slot instruction.
- `active` out 1: 0 once halted.
- `fault` out 1: one-cycle misalignment pulse; tied 0 when the macro is off.

## Operation

**States**
- RUN, PENDING, HALTED.
- Internal register `tgt_q` (32) holds the latched redirect target.

**Redirect request** (in RUN, edge not stalled): a request exists when `pc_ctrl`=1 with `branch_taken`=1, or `pc_ctrl`=2, or `pc_ctrl`=3. Targets are computed from the current `pc_out`:
- Branch: `pc_out`+4+{sext(`instr[15:0]`),2'b00}, 32-bit, wrapping modulo 2^32.
- Jump: {(`pc_out`+4)[31:28], `instr[25:0]`, 2'b00}.
- JR: `reg_readdata`.

**RUN**
- `pc_out` ← `pc_out`+4 (wraps FFFFFFFC→00000000).
- On a redirect request: `tgt_q` ← target and go to PENDING.
- `pc_ctrl`=1 with `branch_taken`=0 is sequential.

**PENDING**
- `pc_out` is the delay slot; `in_delay_slot`=1.
- Next unstalled edge: `pc_out` ← `tgt_q`, go to RUN.
- If `tgt_q`==`HALT_ADDR`: go to HALTED and `active` ← 0 on that same edge.
- Redirect requests presented in PENDING (branch in delay slot) are ignored.

**HALTED**
- `pc_out`=`HALT_ADDR` and `active`=0.
- All inputs, including `exc_req`, are ignored until reset.

**Other rules**
- Sequential stepping that lands on `HALT_ADDR` without a redirect also enters HALTED on that edge.
- `exc_req`=1 in RUN or PENDING, regardless of `stall`: `pc_out` ← `EXC_VECTOR`, state RUN, pending target discarded.
- `stall`=1 without `exc_req`: `pc_out`, state and `tgt_q` all hold; `fault` is 0.

## Timing

- Reset (`rst`=0 at an edge): `pc_out`=`RESET_VECTOR`, `active`=1, `in_delay_slot`=0, `fault`=0, state RUN, `tgt_q`=0. Reset overrides every other input.
- Redirect latency: the redirect is requested on edge N; the delay slot appears at `pc_out` after N; the target appears after edge N+1 (unstalled edges only).
- `in_delay_slot` and `active` are decoded from registered state; neither has a combinational path from any input.
- `pc_link` is purely combinational from `pc_out`.

## Configuration

- Macro `MIPS_PC_ALIGN_CHECK_EN`.
- **Defined:** a redirect target with bits [1:0]≠0 (JR only) latches `EXC_VECTOR` into `tgt_q` instead of the target. `fault` pulses 1 for the single cycle following the latching edge. The delay slot still executes.
- **Undefined:** target bits [1:0] are forced to 00; `fault` is constant 0.

## Test plan

1. **Reset:** `rst`=0 for 2 edges with random inputs → `pc_out`=BFC00000, `active`=1, `in_delay_slot`=0, `fault`=0.
2. **Sequential and not-taken:** 3 edges of `pc_ctrl`=0 → BFC00004, BFC00008, BFC0000C. Then `pc_ctrl`=1 with `branch_taken`=0 → BFC00010.
3. **Taken branch:** at BFC00010 with `instr[15:0]`=0x0004 → BFC00014 with `in_delay_slot`=1, then BFC00024 with `in_delay_slot`=0. With `instr[15:0]`=0xFFFF → BFC00014, then BFC00010.
4. **Stall in PENDING, then exception:** hold `stall`=1 for 2 edges in PENDING → `pc_out` holds BFC00014, then the target follows. On a fresh PENDING, `exc_req`=1 → `pc_out`=BFC00380, pending target never taken.
5. **Halt:** JR with `reg_readdata`=0 at BFC00020 → BFC00024, then 00000000 with `active`=0 on the same edge. 5 further edges with any `pc_ctrl`/`exc_req` → unchanged.
6. **Alignment:** JR with `reg_readdata`=0x80000002.
   - With the macro: delay slot, then BFC00380; `fault`=1 for exactly one cycle.
   - Without the macro: delay slot, then 0x80000000; `fault`=0.
